// File: rtl/contreg_pkg.sv
// Shared definitions for the contreg instruction sequencer.
// Provides the program entry field layout, the sequencer state type and the
// op-to-one-hot instruction decode used to drive contreg's instruction vector.
// Program entry layout: {last[11], op[10:8], data[7:4], rep[3:0]}.
package contreg_pkg;

  localparam int OP_W    = 3;
  localparam int DATA_W  = 4;
  localparam int REP_W   = 4;
  localparam int ENTRY_W = 12;

  localparam int LAST_BIT = 11;
  localparam int OP_HI    = 10;
  localparam int OP_LO    = 8;
  localparam int DATA_HI  = 7;
  localparam int DATA_LO  = 4;
  localparam int REP_HI   = 3;
  localparam int REP_LO   = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Exactly one bit of the instruction vector is set for any op value.
  function automatic logic [7:0] onehot8(input logic [OP_W-1:0] op);
    return 8'd1 << op;
  endfunction

endpackage

// File: rtl/contreg_seq_mem.sv
// Program store for the contreg sequencer.
// DEPTH x ENTRY_W register array with one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset so a program
// survives a sequencer clear.
// Ports:
//   clk    - rising-edge clock
//   we     - write strobe
//   waddr  - write address
//   wdata  - write data (one program entry)
//   raddr  - read address
//   rdata  - read data, combinational from the array
module contreg_seq_mem
  import contreg_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/contreg_seq.sv
// Programmable instruction sequencer feeding the contreg counter/register.
// Steps through a stored program, driving each entry's one-hot instruction
// and load data for rep+1 cycles, with a start/busy/done handshake.
// Ports:
//   clk       - rising-edge clock
//   clr       - synchronous active-high clear (program memory is kept)
//   start     - begin a run from entry 0 when idle
//   stop      - abort a run (or suppress completion) at the next edge
//   prog_we   - program write strobe, honoured only when idle
//   prog_addr - program write address
//   prog_data - program entry {last, op, data, rep}
//   i         - one-hot instruction to contreg, zero when idle
//   e         - load data to contreg
//   busy      - high while the program runs
//   done      - one-cycle pulse on normal completion
//   pc        - index of the entry being driven (held after a run)
module contreg_seq
  import contreg_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic               stop,
  input  logic               prog_we,
  input  logic [AW-1:0]      prog_addr,
  input  logic [ENTRY_W-1:0] prog_data,
  output logic [7:0]         i,
  output logic [DATA_W-1:0]  e,
  output logic               busy,
  output logic               done,
  output logic [AW-1:0]      pc
);

  state_t             state;
  logic [REP_W-1:0]   rep_cnt;
  logic               last_q;
  logic [AW-1:0]      pc_inc;
  logic [AW-1:0]      rd_addr;
  logic [ENTRY_W-1:0] rd_entry;
  logic               mem_we;

  logic               rd_last;
  logic [OP_W-1:0]    rd_op;
  logic [DATA_W-1:0]  rd_data;
  logic [REP_W-1:0]   rd_rep;

  assign pc_inc = pc + AW'(1);

  // Idle fetches entry 0 ready for start; a run pre-fetches the next entry.
  assign rd_addr = (state == RUN) ? pc_inc : '0;

  // Writes only land while idle; clr and stop outrank the write strobe.
  assign mem_we = prog_we && (state == IDLE) && !clr && !stop;

  assign rd_last = rd_entry[LAST_BIT];
  assign rd_op   = rd_entry[OP_HI:OP_LO];
  assign rd_data = rd_entry[DATA_HI:DATA_LO];
  assign rd_rep  = rd_entry[REP_HI:REP_LO];

  contreg_seq_mem #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(prog_addr),
    .wdata(prog_data),
    .raddr(rd_addr),
    .rdata(rd_entry)
  );

  // The last flag of the entry on the outputs is kept locally so completion
  // can be decided without a second memory read port.
  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= IDLE;
      i       <= '0;
      e       <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pc      <= '0;
      rep_cnt <= '0;
      last_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && !prog_we && !stop) begin
            state   <= RUN;
            i       <= onehot8(rd_op);
            e       <= rd_data;
            rep_cnt <= rd_rep;
            last_q  <= rd_last;
            pc      <= '0;
            busy    <= 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            state   <= IDLE;
            i       <= '0;
            e       <= '0;
            busy    <= 1'b0;
            rep_cnt <= '0;
          end else if (rep_cnt != '0) begin
            rep_cnt <= rep_cnt - REP_W'(1);
          end else if (!last_q && (pc != AW'(DEPTH - 1))) begin
            pc      <= pc_inc;
            i       <= onehot8(rd_op);
            e       <= rd_data;
            rep_cnt <= rd_rep;
            last_q  <= rd_last;
          end else begin
            state <= DONE;
            i     <= '0;
            e     <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          i     <= '0;
          e     <= '0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
